// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - ID/WB bus bundle for the register-dependency scoreboard
interface reg_scoreboard_if;
  logic        id_valid;
  logic [3:0]  id_rn;
  logic        id_uses_rn;
  logic [3:0]  id_src2;
  logic        id_two_src;
  logic        id_wb_en;
  logic [3:0]  id_dest;
  logic        flush;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic        Hazard;
  logic        issue;
  logic [15:0] busy_mask;
  logic        drained;
  logic        sb_err;

  modport master (
    output id_valid, id_rn, id_uses_rn, id_src2, id_two_src, id_wb_en, id_dest,
    output flush, wb_en, wb_dest,
    input  Hazard, issue, busy_mask, drained, sb_err
  );

  modport slave (
    input  id_valid, id_rn, id_uses_rn, id_src2, id_two_src, id_wb_en, id_dest,
    input  flush, wb_en, wb_dest,
    output Hazard, issue, busy_mask, drained, sb_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write counters and ID stall control
module reg_scoreboard #(
  parameter int CNT_W     = 2,
  parameter int WB_BYPASS = 1
) (
  input logic               clk,
  input logic               rst,
  reg_scoreboard_if.slave   sb
);

  logic [CNT_W-1:0] cnt_q [16];
  logic [CNT_W-1:0] cnt_d [16];
  logic             sb_err_q, sb_err_d;

  logic [15:0] busy;
  logic [15:0] pend;
  logic [15:0] inc_hit;
  logic [15:0] dec_hit;
  logic        raw, sat, hazard, issue, inc;

  always_comb begin
    sb_err_d = sb_err_q;
    busy     = '0;
    pend     = '0;
    inc_hit  = '0;
    dec_hit  = '0;
    for (int r = 0; r < 16; r++) begin
      cnt_d[r] = cnt_q[r];
      busy[r]  = (cnt_q[r] != '0);
      // a same-cycle retire already lands in the register file on the falling edge
      pend[r]  = busy[r] && !((WB_BYPASS != 0) && sb.wb_en && (sb.wb_dest == 4'(r)));
    end

    raw    = (sb.id_uses_rn && pend[sb.id_rn]) || (sb.id_two_src && pend[sb.id_src2]);
    sat    = sb.id_wb_en && (cnt_q[sb.id_dest] == '1) &&
             !(sb.wb_en && (sb.wb_dest == sb.id_dest));
    hazard = sb.id_valid && !sb.flush && (raw || sat);
    issue  = sb.id_valid && !sb.flush && !hazard;
    inc    = issue && sb.id_wb_en;

    for (int r = 0; r < 16; r++) begin
      inc_hit[r] = inc && (sb.id_dest == 4'(r));
      dec_hit[r] = sb.wb_en && (sb.wb_dest == 4'(r));
      if (inc_hit[r] && !dec_hit[r]) begin
        if (cnt_q[r] == '1) sb_err_d = 1'b1;
        else                cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (dec_hit[r] && !inc_hit[r]) begin
        if (cnt_q[r] == '0) sb_err_d = 1'b1;
        else                cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < 16; r++) cnt_q[r] <= '0;
      sb_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < 16; r++) cnt_q[r] <= cnt_d[r];
      sb_err_q <= sb_err_d;
    end
  end

  assign sb.Hazard    = hazard;
  assign sb.issue     = issue;
  assign sb.busy_mask = busy;
  assign sb.drained   = (busy == '0);
  assign sb.sb_err    = sb_err_q;

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-dependency scoreboard and stall controller for the ID stage. It tracks how many issued instructions still owe a write-back to each of the 16 architectural registers. It raises `Hazard` when the instruction currently in ID reads a register with a pending write, or when its destination counter is saturated. It counts each instruction that leaves ID, and decrements the count when the matching WB write-back retires.

## Interface
Parameters:
- `CNT_W`, 2: width of each per-register pending-write counter; maximum outstanding writes per register = 2^CNT_W − 1.
- `WB_BYPASS`, 1: when 1, a write-back retiring in the same cycle satisfies a pending dependency (register file writes on the falling edge).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-low.
- `id_valid`  in  1  ID holds a real instruction (not a bubble).
- `id_rn`  in  4  first source register.
- `id_uses_rn`  in  1  instruction reads Rn (0 for MOV/MVN/B).
- `id_src2`  in  4  second source (Rm, or Rd for stores).
- `id_two_src`  in  1  instruction reads `id_src2`.
- `id_wb_en`  in  1  instruction will write back, already condition-qualified.
- `id_dest`  in  4  destination register.
- `flush`  in  1  taken branch; the ID instruction is discarded this cycle.
- `wb_en`  in  1  write-back retiring this cycle.
- `wb_dest`  in  4  retiring destination.
- `Hazard`  out  1  stall IF/ID this cycle.
- `issue`  out  1  ID instruction accepted this cycle.
- `busy_mask`  out  16  bit r = counter[r] ≠ 0.
- `drained`  out  1  all counters zero.
- `sb_err`  out  1  sticky: retire on a zero counter, or increment of a saturated counter.

## Operation
- State: 16 counters of `CNT_W` bits and the `sb_err` flag. Nothing else is registered.
- `pend(r)` = counter[r] ≠ 0 and not (`WB_BYPASS` and `wb_en` and `wb_dest` = r).
- `raw` = (`id_uses_rn` and `pend(id_rn)`) or (`id_two_src` and `pend(id_src2)`).
- `sat` = `id_wb_en` and counter[`id_dest`] = all-ones, with no retire of `id_dest` this cycle.
- `Hazard` = `id_valid` and not `flush` and (`raw` or `sat`).
- `issue` = `id_valid` and not `flush` and not `Hazard`.
- `inc` = `issue` and `id_wb_en`. `dec` = `wb_en`.
- Counter update for each register r:
  - +1 when `inc` hits r (via `id_dest`) and `dec` does not.
  - −1 when `dec` hits r (via `wb_dest`) and `inc` does not.
  - Unchanged when both hit r, or neither does.
- Error cases:
  - Decrement of a zero counter: counter holds at 0 and `sb_err` sets.
  - Increment of a saturated counter: cannot occur because `sat` stalls; if it does, counter holds and `sb_err` sets.
- `flush` has priority over everything in ID: no issue, no `Hazard`. Retirements still process during `flush`.
- Instructions already past ID are never cancelled here. Their write-backs always retire.
- `Hazard`, `issue`, `busy_mask` and `drained` are combinational from state and current inputs. There is no internal FSM beyond the counters.

## Timing
- Reset (`rst`=0 at a rising edge):
  - All counters 0 and `sb_err`=0.
  - Outputs then read `busy_mask`=0 and `drained`=1.
  - `Hazard`=0 and `issue`=0 unless `id_valid`.
- Reset mid-operation drops all pending state in one cycle. The pipeline is reset concurrently.
- Increment latency: an issue at edge N is visible in `busy_mask` and `Hazard` from cycle N+1.
- Retire latency:
  - `WB_BYPASS`=1: a dependent instruction issues in the retire cycle itself.
  - `WB_BYPASS`=0: it issues the cycle after.
- Back-to-back writes to the same register by two issued instructions take that counter to 2. Two retirements return it to 0.
- Stalled instruction: `Hazard` stays 1 each cycle until the condition clears. It then issues in the first clear cycle, with no extra bubble.
- Boundaries:
  - Saturated counter plus retire of the same register in the same cycle: issue allowed, counter unchanged.
  - Source equals `id_dest` with no pending write: no hazard.

## Test plan
- Reset, then issue `ADD R1` (`id_wb_en`=1, dest 1) → next cycle `busy_mask`=0x0002, `drained`=0; a following `SUB` reading R1 sees `Hazard`=1 until `wb_en`=1, `wb_dest`=1, and issues in that same cycle (`WB_BYPASS`=1).
- Same stimulus with `WB_BYPASS`=0 → `Hazard` is 1 in the retire cycle and clears one cycle later.
- Issue three writes to R2 with `CNT_W`=2 → counter reaches 3; a fourth write to R2 gives `Hazard`=1 (`sat`). Retire R2 in that same cycle → the fourth issues and the counter stays 3. `sb_err` stays 0 throughout.
- `id_valid`=1 with a RAW dependency on R3 and `flush`=1 → `Hazard`=0, `issue`=0, counters unchanged. A concurrent retire of R3 still decrements its counter.
- Retire R5 while counter[R5]=0 → `sb_err`=1 and stays set. Pulse `rst`=0 for one cycle → `sb_err`=0, `busy_mask`=0, `drained`=1.
- Store (`id_two_src`=1, `id_src2`=Rd=R4) with a pending write to R4 and `id_uses_rn`=0 on an unrelated busy Rn → `Hazard` is driven only by R4; the same store with R4 idle issues immediately.
